bcd_display_scanner: RTL

//   Reads the packed BCD digits produced by the cascaded counter chain and shows

---
 rtl/bcd_display_scanner.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner for a packed BCD snapshot.
// Each digit gets a guard gap, leading zeros can be blanked, and invalid codes are flagged.
module bcd_display_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int GUARD_CYCLES = 2,
   parameter int SEG_ACT_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic                    load,
   input  logic                    blank_en,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    err,
   output logic                    frame_done
);

   localparam int P_W = $clog2(SCAN_DIV);
   localparam int D_W = $clog2(NUM_DIGITS);
   localparam logic [6:0]     SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [P_W-1:0] P_LAST  = P_W'(SCAN_DIV - 1);
   localparam logic [P_W-1:0] P_ENTER = P_W'(GUARD_CYCLES - 1);
   localparam logic [D_W-1:0] D_LAST  = D_W'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {
      ST_GUARD = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
   function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = 7'h40;
      endcase
      return pat;
   endfunction

   logic [4*NUM_DIGITS-1:0] snap_r;
   logic                    err_r;
   logic [P_W-1:0]          p_r, p_nx;
   logic [D_W-1:0]          d_r, d_nx;
   state_t                  state_r, state_nx;
   logic [6:0]              seg_r, seg_nx;
   logic [NUM_DIGITS-1:0]   dig_sel_r, dig_sel_nx;
   logic                    frame_done_r, frame_done_nx;

   logic                    p_wrap_s;
   logic                    bcd_bad_s;
   logic [3:0]              cur_nib_s;
   logic [NUM_DIGITS-1:0]   upper_zero_s;
   logic                    zero_acc_s;
   logic                    blank_s;
   logic [6:0]              drive_seg_s;

   assign seg        = seg_r;
   assign dig_sel    = dig_sel_r;
   assign err        = err_r;
   assign frame_done = frame_done_r;

   // Flag any non-BCD nibble on the incoming digits.
   always_comb begin
      bcd_bad_s = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         bcd_bad_s = bcd_bad_s | (bcd_in[i*4 +: 4] > 4'd9);
      end
   end

   // upper_zero_s[i] is set when snapshot nibbles i..top are all zero.
   always_comb begin
      zero_acc_s   = 1'b1;
      upper_zero_s = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_acc_s      = zero_acc_s & (snap_r[i*4 +: 4] == 4'd0);
         upper_zero_s[i] = zero_acc_s;
      end
   end

   assign p_wrap_s    = (p_r == P_LAST);
   assign cur_nib_s   = snap_r[{d_r, 2'b00} +: 4];
   assign blank_s     = blank_en & (d_r != '0) & upper_zero_s[d_r];
   assign drive_seg_s = (blank_s ? 7'h00 : seg7_decode(cur_nib_s)) ^ SEG_OFF;

   // Snapshot and error flag, updated only on load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_r <= '0;
         err_r  <= 1'b0;
      end else if (load) begin
         snap_r <= bcd_in;
         err_r  <= bcd_bad_s;
      end
   end

   // Next-state: prescaler, digit index, guard/drive phase and registered outputs.
   always_comb begin
      state_nx      = state_r;
      seg_nx        = seg_r;
      dig_sel_nx    = dig_sel_r;
      frame_done_nx = p_wrap_s & (d_r == D_LAST);

      if (p_wrap_s) begin
         p_nx = '0;
      end else begin
         p_nx = p_r + P_W'(1);
      end

      if (p_wrap_s && (d_r == D_LAST)) begin
         d_nx = '0;
      end else if (p_wrap_s) begin
         d_nx = d_r + D_W'(1);
      end else begin
         d_nx = d_r;
      end

      case (state_r)
         ST_GUARD: begin
            if (p_r == P_ENTER) begin
               state_nx   = ST_DRIVE;
               dig_sel_nx = NUM_DIGITS'(1) << d_r;
               seg_nx     = drive_seg_s;
            end else begin
               dig_sel_nx = '0;
               seg_nx     = SEG_OFF;
            end
         end
         ST_DRIVE: begin
            // Digit value is frozen for the whole drive window.
            if (p_wrap_s) begin
               state_nx   = ST_GUARD;
               dig_sel_nx = '0;
               seg_nx     = SEG_OFF;
            end else begin
               state_nx   = ST_DRIVE;
            end
         end
         default: begin
            state_nx   = ST_GUARD;
            dig_sel_nx = '0;
            seg_nx     = SEG_OFF;
         end
      endcase
   end

   // Scan state and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_r          <= '0;
         d_r          <= '0;
         state_r      <= ST_GUARD;
         seg_r        <= SEG_OFF;
         dig_sel_r    <= '0;
         frame_done_r <= 1'b0;
      end else begin
         p_r          <= p_nx;
         d_r          <= d_nx;
         state_r      <= state_nx;
         seg_r        <= seg_nx;
         dig_sel_r    <= dig_sel_nx;
         frame_done_r <= frame_done_nx;
      end
   end

endmodule
